stage_if_pf: RTL and testbench
==============================

Name: stage_if_pf

Overview:
Parametrised prefetching instruction-fetch stage. It reads instruction bytes over the byte-serial memory port with configurable read latency and assembles them little-endian into INST_BYTES-wide instructions. Assembled instructions are buffered with their PCs in a small prefetch FIFO, and ID consumes them through a valid/ready handshake. It sits between pc/branch control and ID and replaces the fixed 8-step counter fetch with a pipelined, flushable engine.

Parameters:
INST_BYTES, 4, bytes per instruction (2..8).
MEM_LAT, 1, cycles from granted address to data on mem_data_i (1..4).
FIFO_DEPTH, 2, prefetch FIFO entries (power of two, 2..8).
RESET_PC, 32'h0, fetch address after reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global run enable; 0 freezes all state
mem_gnt_i  in  1  memory port granted to IF this cycle
mem_data_i  in  8  read byte, valid MEM_LAT cycles after granted request
mem_req_o  out  1  IF requests a byte read this cycle
mem_addr_o  out  32  byte address of request
mem_we_o  out  1  constant 0
redirect_i  in  1  branch/jump redirect, single-cycle pulse
redirect_addr_i  in  32  new fetch PC
id_ready_i  in  1  ID accepts head instruction
inst_valid_o  out  1  FIFO non-empty
inst_o  out  8*INST_BYTES  head instruction; 0 when empty
pc_o  out  32  head PC; 0 when empty
if_stall_req_o  out  1  = ~inst_valid_o

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, byte_idx=0, FIFO empty, in-flight pipe cleared, pending=0, assembly buffer 0. Outputs: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, if_stall_req_o=1.
- rdy=0: every register holds. The memory system pauses identically, so no data is lost. Pops and redirects are ignored.
- Issue: mem_req_o=1 when rdy & ~redirect_i & (byte_idx!=0 | resv<FIFO_DEPTH), where resv=fifo_count+pending. mem_addr_o=fetch_pc+byte_idx, combinational from registers. A request is granted when mem_req_o & mem_gnt_i. On grant, byte_idx increments. On grant of byte_idx=INST_BYTES-1, byte_idx returns to 0 and fetch_pc advances by INST_BYTES (32-bit wrap). Granting byte 0 increments pending. Without a grant, address and index hold.
- Return pipe: a MEM_LAT-deep shift register carries {live, idx, last}. At its output, if live, mem_data_i is written into assembly byte idx, with byte 0 in the LSB. When last arrives, the assembled word and its start PC are pushed into the FIFO that cycle and pending decrements. The instruction becomes visible on inst_valid_o the next cycle.
- Pop: occurs when rdy & inst_valid_o & id_ready_i. The head advances next cycle. Simultaneous push and pop is legal at any fill level. The resv gate makes overflow impossible. It is conservative and ignores a same-cycle pop.
- Redirect has priority over everything in that cycle:
  - FIFO is flushed and pending=0.
  - All live bits in the return pipe clear, so late bytes are discarded.
  - Assembly buffer clears, fetch_pc=redirect_addr_i, byte_idx=0.
  - No request or pop that cycle. The first request to the new address is the next cycle.
  - A push that would coincide with the redirect is dropped.
- Addresses are not alignment-checked.
- Peak throughput: one instruction per INST_BYTES cycles with gnt held high, independent of MEM_LAT.

Test Plan:
1. Defaults, release rst at cycle 0, gnt=1, id_ready=1, mem[0..3]=13 05 10 00 -> requests to addr 0,1,2,3 in cycles 1-4. Cycle 6: inst_valid_o=1, inst_o=32'h00100513, pc_o=0.
2. id_ready=0, gnt=1, 4 instructions in memory -> exactly 2 entries held (PC 0, 4). mem_req_o=0 from the cycle byte 0 of PC 8 would issue. Raise id_ready -> pops PC 0, then PC 4, and issue resumes at addr 8.
3. Redirect to 32'h100 the cycle after byte 1 of PC 4 is granted, with FIFO holding PC 0 -> next cycle inst_valid_o=0 and mem_addr_o=32'h100. The stale byte returning afterwards is ignored. First output has pc_o=32'h100 with the correct bytes.
4. gnt=0 for 3 cycles after byte 1 of PC 0 -> mem_addr_o holds 1 and mem_req_o stays 1. The instruction is correct, 3 cycles later than in scenario 1.
5. MEM_LAT=3, continuous grant/ready -> first valid at cycle 8. Later instructions appear every 4 cycles at PCs 4, 8, 12.
6. rdy=0 for 5 cycles mid-instruction -> all outputs frozen, and the result matches the rdy=1 run shifted by 5. Assert rst=0 mid-fetch -> outputs return to reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/stage_if_pf.sv
// stage_if_pf: prefetching instruction fetch that assembles byte-serial memory reads
// into little-endian instructions and queues them with their PCs for ID.
module stage_if_pf #(
    parameter int          INST_BYTES = 4,
    parameter int          MEM_LAT    = 1,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    mem_gnt_i,
    input  logic [7:0]              mem_data_i,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    output logic                    mem_we_o,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_addr_i,
    input  logic                    id_ready_i,
    output logic                    inst_valid_o,
    output logic [8*INST_BYTES-1:0] inst_o,
    output logic [31:0]             pc_o,
    output logic                    if_stall_req_o
);
    localparam int IW = $clog2(INST_BYTES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = 8*INST_BYTES;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    logic [31:0]   fetch_pc, asm_pc;
    logic [IW-1:0] byte_idx;
    logic [AW:0]   count, pending, resv;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0]  fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc [FIFO_DEPTH];
    logic [W-1:0]  asm_buf, asm_next;
    logic [MEM_LAT-1:0] p_live, p_last;
    logic [IW-1:0] p_idx [MEM_LAT];
    logic redir, grant, grant0, last_byte, ret, push, pop;
    assign redir      = rdy & redirect_i;
    assign resv       = count + pending;
    assign last_byte  = byte_idx == IW'(INST_BYTES-1);
    assign mem_req_o  = rst & rdy & ~redirect_i & (byte_idx != '0 | resv < DEPTH);
    assign mem_addr_o = fetch_pc + 32'(byte_idx);
    assign mem_we_o   = 1'b0;
    assign grant      = mem_req_o & mem_gnt_i;
    assign grant0     = grant & (byte_idx == '0);
    assign ret        = p_live[MEM_LAT-1];
    assign push       = ret & p_last[MEM_LAT-1] & ~redirect_i;
    assign inst_valid_o   = count != '0;
    assign if_stall_req_o = ~inst_valid_o;
    assign pop        = rdy & inst_valid_o & id_ready_i & ~redirect_i;
    assign inst_o     = inst_valid_o ? fifo_inst[rd_ptr] : '0;
    assign pc_o       = inst_valid_o ? fifo_pc[rd_ptr] : '0;
    always_comb begin
        asm_next = asm_buf;
        asm_next[{p_idx[MEM_LAT-1], 3'b000} +: 8] = mem_data_i;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            asm_pc   <= RESET_PC;
            byte_idx <= '0;
            count    <= '0;
            pending  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            asm_buf  <= '0;
            p_live   <= '0;
            p_last   <= '0;
            for (int i = 0; i < MEM_LAT; i++) p_idx[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (rdy) begin
            for (int i = MEM_LAT-1; i > 0; i--) begin
                p_live[i] <= p_live[i-1];
                p_last[i] <= p_last[i-1];
                p_idx[i]  <= p_idx[i-1];
            end
            p_live[0] <= grant;
            p_last[0] <= last_byte;
            p_idx[0]  <= byte_idx;
            if (redir) begin
                // late bytes of the abandoned stream must never reach the buffer
                p_live   <= '0;
                fetch_pc <= redirect_addr_i;
                asm_pc   <= redirect_addr_i;
                byte_idx <= '0;
                count    <= '0;
                pending  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                asm_buf  <= '0;
            end else begin
                if (grant) begin
                    byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    fetch_pc <= last_byte ? fetch_pc + 32'(INST_BYTES) : fetch_pc;
                end
                if (ret) asm_buf <= push ? '0 : asm_next;
                if (push) begin
                    fifo_inst[wr_ptr] <= asm_next;
                    fifo_pc[wr_ptr]   <= asm_pc;
                    wr_ptr <= wr_ptr + 1'b1;
                    asm_pc <= asm_pc + 32'(INST_BYTES);
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
                pending <= pending + {{AW{1'b0}}, grant0} - {{AW{1'b0}}, push};
            end
        end
    end
endmodule

// File: tb/tb_stage_if_pf.sv
// tb_stage_if_pf: scoreboard bench for the prefetching fetch stage, with a second
// instance at MEM_LAT=3 sharing the same control inputs.
module tb_stage_if_pf;
    logic        clk = 1'b0;
    logic        rst, rdy, gnt, redirect_i, id_ready;
    logic [31:0] redirect_addr;
    logic        a_req, a_we, a_valid, a_stall, b_req, b_we, b_valid, b_stall;
    logic [31:0] a_addr, a_inst, a_pc, b_addr, b_inst, b_pc;
    logic [7:0]  a_data, b_data;
    logic [7:0]  mem [512];
    logic [8:0]  a1, b1, b2, b3;
    logic [63:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_if_pf u_a (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_gnt_i(gnt), .mem_data_i(a_data),
        .mem_req_o(a_req), .mem_addr_o(a_addr), .mem_we_o(a_we),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr), .id_ready_i(id_ready),
        .inst_valid_o(a_valid), .inst_o(a_inst), .pc_o(a_pc), .if_stall_req_o(a_stall)
    );

    stage_if_pf #(.MEM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_gnt_i(gnt), .mem_data_i(b_data),
        .mem_req_o(b_req), .mem_addr_o(b_addr), .mem_we_o(b_we),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr), .id_ready_i(id_ready),
        .inst_valid_o(b_valid), .inst_o(b_inst), .pc_o(b_pc), .if_stall_req_o(b_stall)
    );

    // memory returns the byte of the address presented MEM_LAT active cycles earlier
    always @(posedge clk) if (rdy) begin
        a1 <= a_addr[8:0];
        b1 <= b_addr[8:0];
        b2 <= b1;
        b3 <= b2;
    end
    assign a_data = mem[a1];
    assign b_data = mem[b3];

    always @(negedge clk) begin
        if (rst && rdy && !redirect_i && a_valid && id_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%0h inst=%0h, expected no instruction", a_pc, a_inst);
            end else if ({a_pc, a_inst} !== exp_q[0]) begin
                errors++;
                $display("FAIL sb_inst: got pc/inst=%h, expected %h", {a_pc, a_inst}, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"}, a_req, 0);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_inst"}, a_inst, 0);
        chk({tag, "_pc"}, a_pc, 0);
        chk({tag, "_stall"}, a_stall, 1);
        chk({tag, "_we"}, a_we, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; gnt = 1'b1; id_ready = 1'b1;
        redirect_i = 1'b0; redirect_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = (i < 256) ? 8'(i) : 8'(i - 96);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

        // continuous streaming, both latencies
        do_reset();
        chk_reset_outs("rst");
        exp_q.push_back({32'h0, 32'h00100513});
        exp_q.push_back({32'h4, 32'h07060504});
        exp_q.push_back({32'h8, 32'h0B0A0908});
        exp_q.push_back({32'hC, 32'h0F0E0D0C});
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            case (c)
                0: begin chk("s1_req0", a_req, 1); chk("s1_addr0", a_addr, 0); end
                3: chk("s1_addr3", a_addr, 3);
                4: begin chk("s1_valid_c4", a_valid, 0); chk("s1_addr4", a_addr, 4); end
                5: begin
                    chk("s1_valid_c5", a_valid, 1); chk("s1_stall_c5", a_stall, 0);
                    chk("s1_inst", a_inst, 32'h00100513); chk("s1_pc", a_pc, 0);
                end
                6: chk("l3_valid_c6", b_valid, 0);
                7: begin chk("l3_pc0", b_pc, 0); chk("l3_inst0", b_inst, 32'h00100513); end
                11: begin chk("l3_pc4", b_pc, 4); chk("l3_inst4", b_inst, 32'h07060504); end
                15: begin chk("l3_pc8", b_pc, 8); chk("l3_valid8", b_valid, 1); end
                19: begin chk("l3_pc12", b_pc, 12); chk("l3_inst12", b_inst, 32'h0F0E0D0C); end
                default: ;
            endcase
            next_cycle();
        end

        // back-pressure: FIFO fills to two entries and issue stalls
        do_reset();
        exp_q.push_back({32'h0, 32'h00100513});
        exp_q.push_back({32'h4, 32'h07060504});
        exp_q.push_back({32'h8, 32'h0B0A0908});
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            id_ready = (c >= 12);
            #1;
            case (c)
                8: chk("s2_req_c8", a_req, 0);
                9: chk("s2_req_c9", a_req, 0);
                10: begin chk("s2_valid_c10", a_valid, 1); chk("s2_pc_c10", a_pc, 0); end
                12: chk("s2_req_c12", a_req, 0);
                13: begin chk("s2_req_c13", a_req, 1); chk("s2_addr_c13", a_addr, 8); end
                default: ;
            endcase
            next_cycle();
        end

        // redirect flushes queued and in-flight work
        do_reset();
        exp_q.push_back({32'h100, 32'hA3A2A1A0});
        rst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            id_ready = (c >= 7);
            redirect_i = (c == 6);
            redirect_addr = (c == 6) ? 32'h100 : 32'h0;
            #1;
            case (c)
                5: chk("s3_addr_c5", a_addr, 5);
                6: begin chk("s3_req_redir", a_req, 0); chk("s3_valid_c6", a_valid, 1); end
                7: begin
                    chk("s3_valid_c7", a_valid, 0); chk("s3_addr_c7", a_addr, 32'h100);
                    chk("s3_req_c7", a_req, 1);
                end
                11: chk("s3_valid_c11", a_valid, 0);
                12: begin chk("s3_pc", a_pc, 32'h100); chk("s3_inst", a_inst, 32'hA3A2A1A0); end
                default: ;
            endcase
            next_cycle();
        end

        // grant withheld for three cycles on byte 1
        do_reset();
        exp_q.push_back({32'h0, 32'h00100513});
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            gnt = !(c >= 1 && c <= 3);
            #1;
            if (c >= 1 && c <= 4) begin
                chk("s4_hold_addr", a_addr, 1);
                chk("s4_hold_req", a_req, 1);
            end
            case (c)
                5: chk("s4_addr_c5", a_addr, 2);
                7: chk("s4_valid_c7", a_valid, 0);
                8: begin chk("s4_pc", a_pc, 0); chk("s4_inst", a_inst, 32'h00100513); end
                default: ;
            endcase
            next_cycle();
        end

        // rdy freeze mid-instruction, then async reset mid-fetch
        do_reset();
        exp_q.push_back({32'h0, 32'h00100513});
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rdy = !(c >= 2 && c <= 6);
            #1;
            if (c >= 2 && c <= 6) begin
                chk("s6_frz_addr", a_addr, 2);
                chk("s6_frz_req", a_req, 0);
                chk("s6_frz_valid", a_valid, 0);
            end
            case (c)
                7: begin chk("s6_addr_c7", a_addr, 2); chk("s6_req_c7", a_req, 1); end
                8: chk("s6_addr_c8", a_addr, 3);
                9: chk("s6_valid_c9", a_valid, 0);
                10: begin chk("s6_pc", a_pc, 0); chk("s6_inst", a_inst, 32'h00100513); end
                default: ;
            endcase
            next_cycle();
        end
        chk("s6_addr_c12", a_addr, 7);
        rst = 1'b0;
        #1;
        chk_reset_outs("arst");
        next_cycle();
        rst = 1'b1;
        #1;
        chk("s6_restart_req", a_req, 1);
        chk("s6_restart_addr", a_addr, 0);
        next_cycle();
        chk("s6_restart_addr1", a_addr, 1);

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
